// File: rtl/param_plru_pkg.sv
// Shared types and tree-PLRU helpers for the replacement-state tracker.
// Tree bits are handled at a fixed maximum width (up to 64 ways) so one
// function body serves every Ways value; callers truncate to their size.
package param_plru_pkg;

  typedef enum logic [0:0] {IDLE, SWEEP} plru_state_e;

  localparam int unsigned MaxLevels = 6;
  localparam int unsigned MaxNodes  = (1 << MaxLevels) - 1;

  typedef logic [MaxNodes-1:0]  plru_bits_t;
  typedef logic [MaxLevels-1:0] plru_way_t;
  typedef logic [MaxLevels-1:0] plru_node_t;

  // Walk from the root following the node bits; 0 = go left, 1 = go right.
  function automatic plru_way_t plru_victim(input plru_bits_t bits, input int unsigned levels);
    plru_node_t node;
    plru_way_t  way;
    logic       b;
    node = '0;
    way  = '0;
    for (int unsigned l = 0; l < MaxLevels; l++) begin
      if (l < levels) begin
        b    = bits[node];
        way  = {way[MaxLevels-2:0], b};
        node = {node[MaxLevels-2:0], 1'b0} + plru_node_t'(1) + plru_node_t'(b);
      end
    end
    return way;
  endfunction

  // Point every node on the path to 'way' away from it; off-path bits keep their value.
  function automatic plru_bits_t plru_update(input plru_bits_t bits, input plru_way_t way,
                                             input int unsigned levels);
    plru_bits_t res;
    plru_node_t node;
    plru_way_t  w;
    logic       dir;
    res  = bits;
    node = '0;
    // Left-align the way index so its MSB (the root decision) sits at the top.
    w    = way << (MaxLevels - levels);
    for (int unsigned l = 0; l < MaxLevels; l++) begin
      if (l < levels) begin
        dir       = w[MaxLevels-1];
        res[node] = ~dir;
        w         = w << 1;
        node      = {node[MaxLevels-2:0], 1'b0} + plru_node_t'(1) + plru_node_t'(dir);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational update and victim decode for one set's PLRU tree bits.
module plru_tree_logic
  import param_plru_pkg::*;
#(
  parameter int unsigned Ways = 4,
  parameter int unsigned WayW = $clog2(Ways)
) (
  input  logic [Ways-2:0] i_bits,
  input  logic [WayW-1:0] i_way,
  output logic [Ways-2:0] o_bits,
  output logic [WayW-1:0] o_victim
);

  assign o_bits   = (Ways-1)'(plru_update(plru_bits_t'(i_bits), plru_way_t'(i_way), WayW));
  assign o_victim = WayW'(plru_victim(plru_bits_t'(i_bits), WayW));

endmodule

// File: rtl/param_plru_tracker.sv
// Per-set tree pseudo-LRU state with touch update, victim lookup (optional
// same-cycle forwarding) and a one-set-per-cycle flush sweep.
module param_plru_tracker
  import param_plru_pkg::*;
#(
  parameter int unsigned Ways   = 4,
  parameter int unsigned Sets   = 8,
  parameter int unsigned BYPASS = 0,
  parameter int unsigned SetW   = $clog2(Sets),
  parameter int unsigned WayW   = $clog2(Ways)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_touch,
  input  logic [SetW-1:0] i_touch_set,
  input  logic [WayW-1:0] i_touch_way,
  input  logic [SetW-1:0] i_rindex,
  output logic [WayW-1:0] o_victim_way,
  output logic            o_victim_valid,
  input  logic            i_flush,
  output logic            o_busy
);

  logic [Ways-2:0] r_tree [Sets];
  plru_state_e     r_state;
  logic [SetW-1:0] r_cnt;
  logic            r_busy;
  logic            r_victim_valid;

  logic            w_touch_en;
  logic            w_fwd;
  logic [Ways-2:0] w_upd_bits;
  logic [Ways-2:0] w_vic_src;
  logic [WayW-1:0] w_upd_victim_unused;
  logic [Ways-2:0] w_vic_bits_next_unused;

  // A touch only lands in IDLE and loses to a simultaneous flush.
  assign w_touch_en = i_touch && (r_state == IDLE) && !i_flush;
  assign w_fwd      = (BYPASS != 0) && w_touch_en && (i_touch_set == i_rindex);
  assign w_vic_src  = w_fwd ? w_upd_bits : r_tree[i_rindex];

  plru_tree_logic #(
    .Ways (Ways),
    .WayW (WayW)
  ) u_update (
    .i_bits   (r_tree[i_touch_set]),
    .i_way    (i_touch_way),
    .o_bits   (w_upd_bits),
    .o_victim (w_upd_victim_unused)
  );

  plru_tree_logic #(
    .Ways (Ways),
    .WayW (WayW)
  ) u_victim (
    .i_bits   (w_vic_src),
    .i_way    (i_touch_way),
    .o_bits   (w_vic_bits_next_unused),
    .o_victim (o_victim_way)
  );

  // Control FSM, tree storage and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_victim_valid <= 1'b1;
      r_tree         <= '{default: '0};
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_flush) begin
            r_state        <= SWEEP;
            r_cnt          <= '0;
            r_busy         <= 1'b1;
            r_victim_valid <= 1'b0;
          end else if (i_touch) begin
            r_tree[i_touch_set] <= w_upd_bits;
          end
        end
        SWEEP: begin
          r_tree[r_cnt] <= '0;
          r_cnt         <= r_cnt + SetW'(1);
          // Last set written: counter wrap is the exit, never an extra write.
          if (r_cnt == SetW'(Sets - 1)) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_victim_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_victim_valid = r_victim_valid;

endmodule
